// File: rtl/floor_ec_5.sv
// Five-floor car controller: latches floor requests and serves them in scan order, moving one floor per clock.
// Optional stop at served floors is enabled by defining FLOOR_EC_DWELL_EN.
//  state    | meaning
//  ST_IDLE  | car parked; clears the request at this floor and chooses a direction if work remains
//  ST_MOVE  | car steps one floor per edge toward the remaining work in r_dir
//  ST_DWELL | (FLOOR_EC_DWELL_EN only) car held at a served floor for DWELL_CYCLES edges
module floor_ec_5
`ifdef FLOOR_EC_DWELL_EN
#(
    parameter int DWELL_CYCLES = 2
)
`endif
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_ra,
    input  logic       i_rb,
    input  logic       i_rc,
    input  logic       i_rd,
    input  logic       i_re,
    output logic [2:0] o_floor
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MOVE  = 2'd1
`ifdef FLOOR_EC_DWELL_EN
        , ST_DWELL = 2'd2
`endif
    } state_t;

    localparam logic DIR_UP = 1'b1;

    state_t     r_state;
    logic [2:0] r_floor;
    logic       r_dir;
    logic [4:0] r_pend;

`ifdef FLOOR_EC_DWELL_EN
    localparam int DW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    logic [DW-1:0] r_dwell;
`endif

    logic [4:0] w_req;
    logic [2:0] w_next_floor;
    logic [4:0] w_rem_here;
    logic [4:0] w_rem_next;
    logic       w_floor_ok;

    function automatic logic [4:0] f_bit(input logic [2:0] f);
        return 5'd1 << f;
    endfunction

    function automatic logic f_ahead(input logic dir, input logic [2:0] f, input logic [4:0] req);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (req[i] && ((dir == DIR_UP) ? (3'(i) > f) : (3'(i) < f)))
                hit = 1'b1;
        end
        return hit;
    endfunction

    assign w_req        = r_pend | {i_re, i_rd, i_rc, i_rb, i_ra};
    assign w_next_floor = (r_dir == DIR_UP) ? r_floor + 3'd1 : r_floor - 3'd1;
    assign w_rem_here   = w_req & ~f_bit(r_floor);
    assign w_rem_next   = w_req & ~f_bit(w_next_floor);
    assign w_floor_ok   = (r_floor <= 3'd4);
    assign o_floor      = r_floor;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_floor <= 3'd0;
            r_dir   <= DIR_UP;
            r_pend  <= 5'b0;
`ifdef FLOOR_EC_DWELL_EN
            r_dwell <= '0;
`endif
        end else if (!w_floor_ok) begin
            r_state <= ST_IDLE;
            r_floor <= 3'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_pend <= w_rem_here;
                    if (w_rem_here != 5'b0) begin
                        if (!f_ahead(r_dir, r_floor, w_rem_here))
                            r_dir <= ~r_dir;
                        r_state <= ST_MOVE;
                    end
                end
                ST_MOVE: begin
                    // Nothing ahead means no safe step exists; park instead of running off the shaft.
                    if (!f_ahead(r_dir, r_floor, w_req)) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_floor <= w_next_floor;
                        r_pend  <= w_rem_next;
`ifdef FLOOR_EC_DWELL_EN
                        if ((w_req & f_bit(w_next_floor)) != 5'b0) begin
                            r_state <= ST_DWELL;
                            r_dwell <= DW'(DWELL_CYCLES - 1);
                        end else
`endif
                        if (f_ahead(r_dir, w_next_floor, w_rem_next))
                            r_state <= ST_MOVE;
                        else
                            r_state <= ST_IDLE;
                    end
                end
`ifdef FLOOR_EC_DWELL_EN
                ST_DWELL: begin
                    r_pend <= w_rem_here;
                    if (r_dwell == '0) begin
                        r_state <= f_ahead(r_dir, r_floor, w_rem_here) ? ST_MOVE : ST_IDLE;
                    end else begin
                        r_dwell <= r_dwell - 1'b1;
                    end
                end
`endif
                default: begin
                    r_state <= ST_IDLE;
                    r_floor <= 3'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_floor_ec_5.sv
// Bench for floor_ec_5 (default build): directed scenarios plus random request traffic,
// each edge checked against a floor-level scan model of the car.
module tb_floor_ec_5;

    logic       clk;
    logic       rst;
    logic [4:0] req;
    logic [2:0] floor_o;

    int total = 0;
    int bad   = 0;

    // reference model state
    int       m_floor;
    bit       m_up;
    bit       m_moving;
    bit [4:0] m_pend;

    floor_ec_5 dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_ra   (req[0]),
        .i_rb   (req[1]),
        .i_rc   (req[2]),
        .i_rd   (req[3]),
        .i_re   (req[4]),
        .o_floor(floor_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit work_beyond(bit up, int f, bit [4:0] r);
        for (int fl = 0; fl < 5; fl++)
            if (r[fl] && (up ? fl > f : fl < f)) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_floor  = 0;
        m_up     = 1'b1;
        m_moving = 1'b0;
        m_pend   = '0;
    endtask

    task automatic model_edge(input bit [4:0] r);
        bit [4:0] want;
        want = m_pend | r;
        if (!m_moving) begin
            want[m_floor] = 1'b0;
            m_pend = want;
            if (want != 0) begin
                if (!work_beyond(m_up, m_floor, want)) m_up = !m_up;
                m_moving = 1'b1;
            end
        end else begin
            m_floor = m_up ? m_floor + 1 : m_floor - 1;
            want[m_floor] = 1'b0;
            m_pend = want;
            m_moving = work_beyond(m_up, m_floor, want);
        end
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // drive requests for one edge, advance model, sample 1 time unit after the edge
    task automatic cyc(input bit [4:0] r, input string tag);
        req = r;
        @(posedge clk);
        model_edge(r);
        #1;
        req = '0;
        chk(tag, int'(floor_o), m_floor);
    endtask

    task automatic async_reset(input string tag);
        rst = 1'b1;
        model_reset();
        #1;
        chk(tag, int'(floor_o), 0);
        #2;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        req = '0;
        model_reset();
        #12;
        chk("reset_floor", int'(floor_o), 0);
        rst = 1'b0;

        // 1: no requests, parked at 0
        for (int i = 0; i < 20; i++) cyc(5'b00000, "idle_hold");
        chk("idle_pend", int'(dut.r_pend), 0);

        // 2: pulse E from 0 -> 1 idle edge, then 1,2,3,4
        cyc(5'b10000, "s2_start");
        chk("s2_start_floor", int'(floor_o), 0);
        for (int i = 1; i <= 4; i++) begin
            cyc(5'b00000, "s2_climb");
            chk("s2_climb_const", int'(floor_o), i);
        end
        cyc(5'b00000, "s2_park");
        chk("s2_park_floor", int'(floor_o), 4);
        chk("s2_pend", int'(dut.r_pend), 0);

        // 3: at 4, A and C together -> 3,2,1,0
        cyc(5'b00101, "s3_start");
        for (int i = 3; i >= 0; i--) begin
            cyc(5'b00000, "s3_descend");
            chk("s3_descend_const", int'(floor_o), i);
        end
        cyc(5'b00000, "s3_park");
        chk("s3_pend", int'(dut.r_pend), 0);

        // 4: go to 2, then request 2 while parked there
        cyc(5'b00100, "s4_go");
        repeat (3) cyc(5'b00000, "s4_travel");
        chk("s4_at2", int'(floor_o), 2);
        cyc(5'b00100, "s4_same_floor");
        repeat (3) cyc(5'b00000, "s4_hold");
        chk("s4_still2", int'(floor_o), 2);
        chk("s4_pend", int'(dut.r_pend), 0);

        // 5: 2 -> 4 with B requested while passing 3
        cyc(5'b10000, "s5_start");
        cyc(5'b00000, "s5_to3");
        chk("s5_at3", int'(floor_o), 3);
        cyc(5'b00010, "s5_to4_rb");
        chk("s5_at4", int'(floor_o), 4);
        repeat (6) cyc(5'b00000, "s5_return");
        chk("s5_stop1", int'(floor_o), 1);
        chk("s5_pend", int'(dut.r_pend), 0);

        // 6: reset while moving at 3 toward 4
        cyc(5'b10000, "s6_start");
        cyc(5'b00000, "s6_to2");
        cyc(5'b00000, "s6_to3");
        chk("s6_at3", int'(floor_o), 3);
        async_reset("s6_async_rst");
        repeat (5) cyc(5'b00000, "s6_after_rst");
        chk("s6_pend_lost", int'(dut.r_pend), 0);

        // all five at once from floor 0
        cyc(5'b11111, "all_start");
        repeat (6) cyc(5'b00000, "all_run");
        chk("all_end", int'(floor_o), 4);

        // random traffic
        for (int i = 0; i < 600; i++) begin
            bit [4:0] r;
            r = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'b0;
            if ($urandom_range(0, 99) == 0) async_reset("rnd_rst");
            cyc(r, "rnd");
            total++;
            assert (floor_o <= 3'd4) else begin
                bad++;
                $error("FAIL rnd_bound observed=%0d expected<=4", floor_o);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
